en_serializer: RTL and testbench

EN_SERIALIZER -- requirements
Module: en_serializer

---
 rtl/en_ser_pkg.sv | 13 +
 rtl/en_ser_counter.sv | 32 +++
 rtl/en_serializer.sv | 178 +++++++++++++++++
 tb/tb_en_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/en_ser_pkg.sv
// Shared definitions for the enable-strobed serializer: FSM states and default geometry.
package en_ser_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/en_ser_counter.sv
// Loadable down-counter with zero and one flags; saturates at zero instead of wrapping.
module en_ser_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_one
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/en_serializer.sv
// Parallel-to-serial shifter with a bit strobe (en), end-of-word flag (last) and optional idle gap.
// state | meaning
// IDLE  | ready=1, waiting for valid
// SHIFT | en=1, one bit per cycle, WIDTH cycles
// GAP   | en=0, ready=0 for GAP_CYCLES cycles
module en_serializer
  import en_ser_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int LSB_FIRST  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             en,
  output logic             d,
  output logic             last
);

  localparam int BIT_CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]       r_rst_sync;
  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_en;
  logic             r_d;
  logic             r_last;
  logic             r_ready;

  logic             w_run;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_en_nxt;
  logic             w_d_nxt;
  logic             w_last_nxt;
  logic             w_ready_nxt;
  logic             w_cnt_clr;
  logic             w_bit_load;
  logic             w_bit_dec;
  logic             w_bit_zero;
  logic             w_bit_one;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_gap_zero;
  logic             w_gap_one;

  function automatic logic f_head(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] f_adv(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Reset asserts asynchronously but is released to the FSM only after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  en_ser_counter #(.W(BIT_CNT_W)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_bit_load),
    .i_load_val (BIT_CNT_W'(WIDTH - 1)),
    .i_dec      (w_bit_dec),
    .o_zero     (w_bit_zero),
    .o_one      (w_bit_one)
  );

  en_ser_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_gap_load),
    .i_load_val (GAP_CNT_W'(GAP_CYCLES)),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero),
    .o_one      (w_gap_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_en    <= 1'b0;
      r_d     <= 1'b0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_en    <= w_en_nxt;
      r_d     <= w_d_nxt;
      r_last  <= w_last_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Bit counter holds the number of bits still to come after the one on d.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_en_nxt    = 1'b0;
    w_d_nxt     = 1'b0;
    w_last_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    w_cnt_clr   = 1'b0;
    w_bit_load  = 1'b0;
    w_bit_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    if (!w_run) begin
      w_state_nxt = ST_IDLE;
      w_shift_nxt = '0;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid && r_ready) begin
            w_state_nxt = ST_SHIFT;
            w_shift_nxt = f_adv(data_in);
            w_en_nxt    = 1'b1;
            w_d_nxt     = f_head(data_in);
            w_bit_load  = 1'b1;
            w_gap_load  = 1'b1;
          end else begin
            w_ready_nxt = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_bit_zero) begin
            w_shift_nxt = '0;
            if (GAP_CYCLES > 0) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_IDLE;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_en_nxt    = 1'b1;
            w_d_nxt     = f_head(r_shift);
            w_shift_nxt = f_adv(r_shift);
            w_last_nxt  = w_bit_one;
            w_bit_dec   = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_gap_zero || w_gap_one) begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
          end else begin
            w_gap_dec = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign en    = r_en;
  assign d     = r_d;
  assign last  = r_last;

endmodule

// File: tb/tb_en_serializer.sv
// Bench for en_serializer: four instances (GAP_CYCLES 0..3, instance 2 LSB-first) with a word scoreboard.
module tb_en_serializer;

  logic       clk = 1'b0;
  logic [3:0] rst_n_a;
  logic [3:0] valid_a;
  logic [7:0] din_a [4];
  wire  [3:0] ready_a;
  wire  [3:0] en_a;
  wire  [3:0] d_a;
  wire  [3:0] last_a;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  int         nb      [4];
  logic [7:0] acc     [4];
  int         low_run [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    en_serializer #(
      .WIDTH      (8),
      .GAP_CYCLES (k),
      .LSB_FIRST  ((k == 2) ? 1 : 0)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n_a[k]),
      .data_in (din_a[k]),
      .valid   (valid_a[k]),
      .ready   (ready_a[k]),
      .en      (en_a[k]),
      .d       (d_a[k]),
      .last    (last_a[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void qpush(input int k, input logic [7:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic void qflush(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endfunction

  // Monitor: rebuild words from en/d, check last, idle outputs and minimum en-low spacing.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n_a[k]) begin
        nb[k]      = 0;
        acc[k]     = 8'h00;
        low_run[k] = 100;
      end else if (en_a[k]) begin
        if (nb[k] == 0) chk($sformatf("gap_min%0d", k), 32'(low_run[k] >= k + 1), 32'd1);
        low_run[k] = 0;
        if (k == 2) acc[k][nb[k]] = d_a[k];
        else        acc[k] = {acc[k][6:0], d_a[k]};
        nb[k]++;
        chk($sformatf("last%0d", k), 32'(last_a[k]), 32'(nb[k] == 8));
        if (nb[k] == 8) begin
          if (qsize(k) == 0) begin
            chk($sformatf("unexpected_word%0d", k), 32'(acc[k]), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("word%0d", k), 32'(acc[k]), 32'(qpop(k)));
          end
          nb[k]  = 0;
          acc[k] = 8'h00;
        end
      end else begin
        if (low_run[k] < 100) low_run[k]++;
        chk($sformatf("idle_out%0d", k), 32'({d_a[k], last_a[k]}), 32'd0);
      end
    end
  end

  // Returns at the negedge following the accept edge (first bit visible there).
  task automatic send(input int k, input logic [7:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_a[k] && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("send_ready%0d", k), 32'(ready_a[k]), 32'd1);
    if (ready_a[k]) begin
      din_a[k]   = w;
      valid_a[k] = 1'b1;
      qpush(k, w);
      @(negedge clk);
      valid_a[k] = 1'b0;
      din_a[k]   = 8'($urandom);
    end
  endtask

  task automatic trace(input int k, input logic [7:0] w, input bit lsb, input int gap);
    logic bit_v;
    for (int c = 1; c <= 8 + gap + 1; c++) begin
      if (c > 1) @(negedge clk);
      bit_v = lsb ? w[c-1] : ((c <= 8) ? w[8-c] : 1'b0);
      chk($sformatf("tr_en%0d_c%0d", k, c), 32'(en_a[k]), 32'(c <= 8));
      chk($sformatf("tr_d%0d_c%0d", k, c), 32'(d_a[k]), 32'((c <= 8) && bit_v));
      chk($sformatf("tr_last%0d_c%0d", k, c), 32'(last_a[k]), 32'(c == 8));
      chk($sformatf("tr_ready%0d_c%0d", k, c), 32'(ready_a[k]), 32'(c > 8 + gap));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   nacc;
    int   cnt;
    logic en_s [19];
    logic d_s  [19];

    rst_n_a = 4'h0;
    valid_a = 4'h0;
    for (int k = 0; k < 4; k++) din_a[k] = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(ready_a[k]), 32'd0);
      chk($sformatf("rst_out%0d", k), 32'({en_a[k], d_a[k], last_a[k]}), 32'd0);
    end
    rst_n_a = 4'hF;
    t = 0;
    while (ready_a != 4'hF && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("release_ready", 32'(ready_a), 32'hF);

    // MSB-first A5, one gap cycle
    send(1, 8'hA5);
    trace(1, 8'hA5, 1'b0, 1);

    // LSB-first 01, two gap cycles
    send(2, 8'h01);
    trace(2, 8'h01, 1'b1, 2);

    // valid held high, FF then 00, no gap: bursts separated by one en-low cycle
    t = 0;
    while (!ready_a[0] && t < 60) begin
      @(negedge clk);
      t++;
    end
    din_a[0]   = 8'hFF;
    valid_a[0] = 1'b1;
    qpush(0, 8'hFF);
    nacc = 1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      en_s[c] = en_a[0];
      d_s[c]  = d_a[0];
      if (c == 1) din_a[0] = 8'h00;
      if (nacc == 1 && ready_a[0]) begin
        qpush(0, 8'h00);
        nacc = 2;
      end else if (nacc == 2) begin
        valid_a[0] = 1'b0;
      end
    end
    valid_a[0] = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("b2b_en_c%0d", c), 32'(en_s[c]), 32'((c <= 8) || (c >= 10 && c <= 17)));
      chk($sformatf("b2b_d_c%0d", c), 32'(d_s[c]), 32'(c <= 8));
    end

    // valid pulsed mid-word is ignored
    send(1, 8'h5A);
    cnt = en_a[1] ? 1 : 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        din_a[1]   = 8'h3C;
        valid_a[1] = 1'b1;
      end else begin
        valid_a[1] = 1'b0;
      end
      if (en_a[1]) cnt++;
    end
    chk("ignored_valid_en_cycles", 32'(cnt), 32'd8);

    // asynchronous reset at bit 4 of A5
    send(1, 8'hA5);
    repeat (3) @(negedge clk);
    chk("pre_rst_en", 32'(en_a[1]), 32'd1);
    #2 rst_n_a[1] = 1'b0;
    #1;
    chk("async_rst_out", 32'({en_a[1], d_a[1], last_a[1]}), 32'd0);
    chk("async_rst_ready", 32'(ready_a[1]), 32'd0);
    qflush(1);
    repeat (2) @(negedge clk);
    rst_n_a[1] = 1'b1;
    t = 0;
    while (!ready_a[1] && t < 8) begin
      @(negedge clk);
      chk("post_rst_en", 32'(en_a[1]), 32'd0);
      t++;
    end
    chk("post_rst_ready", 32'(ready_a[1]), 32'd1);
    repeat (12) @(negedge clk);
    chk("post_rst_quiet", 32'(nb[1]), 32'd0);

    // randomized words across all gap settings
    for (int i = 0; i < 100; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      send(k, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_q%0d", k), 32'(qsize(k)), 32'd0);
      chk($sformatf("drain_nb%0d", k), 32'(nb[k]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
